shake256_sched: RTL and testbench

- Shares one SHAKE256 core between NUM_REQ requesters under round-robin arbitration.
- Per job: latch the winner's single-block message and length, hold the core in reset for RST_CYCLES, release it, wait for squeezed, capture the 1088-bit hash, return it to the winner over a valid/ready response channel.
- Sits between requester logic and the SHAKE256 core.
- Includes a length check and a run timeout.

---
 rtl/shake_pkg.sv | 22 ++
 rtl/shake256_sched_rr_arbiter.sv | 35 +++
 rtl/shake256_sched.sv | 137 +++++++++++++
 tb/tb_shake256_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE256 job scheduler.
package shake_pkg;

  localparam int RATE_BITS = 1088;
  localparam int LEN_W     = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } sched_state_t;

  typedef logic [RATE_BITS-1:0] rate_t;
  typedef logic [LEN_W-1:0]     len_t;

  // A single-block message may not exceed the sponge rate.
  function automatic logic len_too_long(input len_t len);
    return len > LEN_W'(RATE_BITS);
  endfunction

endpackage

// File: rtl/shake256_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after
// the pointer, searching circularly, so the last winner ranks lowest.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] slot;

  // Walk pointer+1 .. pointer+N (mod N) and take the first active request.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path can
    // leave one unassigned and infer a latch.
    grant = '0;
    index = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 1; k <= N; k++) begin
      slot = IW'((int'(pointer) + k) % N);
      if (enable && !found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        index       = slot;
      end
    end
  end

endmodule

// File: rtl/shake256_sched.sv
// Shares one SHAKE256 core between NUM_REQ requesters: latch the winner's
// block, pulse the core reset, run until squeezed (or timeout) and hand the
// captured digest back over a valid/ready response channel.
module shake256_sched
  import shake_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 255,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*RATE_BITS-1:0] req_message,
  input  logic [NUM_REQ*LEN_W-1:0]     req_length,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDX_W-1:0]             rsp_id,
  output logic                         rsp_error,
  output rate_t                        rsp_hash,
  output logic                         busy,
  output logic                         core_reset,
  output rate_t                        core_message,
  output len_t                         core_length,
  input  logic                         core_squeezed,
  input  rate_t                        core_hash
);

  localparam int CNT_MAX = (RST_CYCLES > MAX_CYCLES) ? RST_CYCLES : MAX_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t     state, next_state;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic             handshake;
  logic             len_bad;
  logic             load_done;
  logic             run_timeout;
  rate_t            sel_message;
  len_t             sel_length;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .pointer (pointer),
    .enable  (state == IDLE),
    .grant   (grant),
    .index   (grant_idx)
  );

  assign req_ready   = grant;
  assign handshake   = |(req_valid & grant);
  assign len_bad     = len_too_long(sel_length);
  assign load_done   = (cnt == CNT_W'(RST_CYCLES - 1));
  assign run_timeout = (cnt == CNT_W'(MAX_CYCLES - 1));
  assign busy        = (state != IDLE);
  assign core_reset  = (state != RUN);
  assign rsp_valid   = (state == RESP);

  // One-hot mux of the granted requester's message and length.
  always_comb begin
    sel_message = '0;
    sel_length  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_message = req_message[i*RATE_BITS +: RATE_BITS];
        sel_length  = req_length[i*LEN_W +: LEN_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the values from before the edge.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; squeeze takes precedence over timeout in RUN.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (handshake) next_state = len_bad ? RESP : LOAD;
      LOAD: if (load_done) next_state = RUN;
      RUN:  if (core_squeezed || run_timeout) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Job datapath: grant latching, phase counter and response capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer      <= IDX_W'(NUM_REQ - 1);
      cnt          <= '0;
      rsp_id       <= '0;
      rsp_error    <= 1'b0;
      // NOTE: the wide message and hash registers are reset deliberately so
      // neither the core nor a requester ever sees a stale block after reset.
      rsp_hash     <= '0;
      core_message <= '0;
      core_length  <= '0;
    end else begin
      if (next_state != state)                cnt <= '0;
      else if (state == LOAD || state == RUN) cnt <= cnt + CNT_W'(1);

      if (state == IDLE && handshake) begin
        pointer      <= grant_idx;
        rsp_id       <= grant_idx;
        core_message <= sel_message;
        core_length  <= sel_length;
        if (len_bad) begin
          rsp_error <= 1'b1;
          rsp_hash  <= '0;
        end
      end

      if (state == RUN) begin
        if (core_squeezed) begin
          rsp_hash  <= core_hash;
          rsp_error <= 1'b0;
        end else if (run_timeout) begin
          rsp_hash  <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shake256_sched.sv
// Directed bench for shake256_sched: table-driven round-robin jobs plus
// hand-written latency, backpressure, bad-length, timeout and reset cases.
module tb_shake256_sched;
  import shake_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Main instance (long timeout).
  logic [N-1:0]           req_valid, req_ready;
  logic [N*RATE_BITS-1:0] req_message;
  logic [N*LEN_W-1:0]     req_length;
  logic                   rsp_valid, rsp_ready, rsp_error, busy, core_reset, core_squeezed;
  logic [IW-1:0]          rsp_id;
  rate_t                  rsp_hash, core_message, core_hash;
  len_t                   core_length;

  // Timeout instance (MAX_CYCLES = 16).
  logic [N-1:0]           t_req_valid, t_req_ready;
  logic [N*RATE_BITS-1:0] t_req_message;
  logic [N*LEN_W-1:0]     t_req_length;
  logic                   t_rsp_valid, t_rsp_ready, t_rsp_error, t_busy, t_core_reset, t_core_squeezed;
  logic [IW-1:0]          t_rsp_id;
  rate_t                  t_rsp_hash, t_core_message, t_core_hash;
  len_t                   t_core_length;

  shake256_sched #(.NUM_REQ(N), .RST_CYCLES(2), .MAX_CYCLES(255)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_message(req_message), .req_length(req_length),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_error(rsp_error), .rsp_hash(rsp_hash), .busy(busy),
    .core_reset(core_reset), .core_message(core_message), .core_length(core_length),
    .core_squeezed(core_squeezed), .core_hash(core_hash)
  );

  shake256_sched #(.NUM_REQ(N), .RST_CYCLES(2), .MAX_CYCLES(16)) dut_t (
    .clock(clock), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_message(t_req_message), .req_length(t_req_length),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
    .rsp_error(t_rsp_error), .rsp_hash(t_rsp_hash), .busy(t_busy),
    .core_reset(t_core_reset), .core_message(t_core_message), .core_length(t_core_length),
    .core_squeezed(t_core_squeezed), .core_hash(t_core_hash)
  );

  // Core models: count cycles since reset release, squeeze at a set count.
  int run_cnt = 0, sq_delay = 1000;
  int t_run_cnt = 0, t_sq_delay = 1000;
  always @(posedge clock) run_cnt   <= core_reset   ? 0 : run_cnt + 1;
  always @(posedge clock) t_run_cnt <= t_core_reset ? 0 : t_run_cnt + 1;
  assign core_squeezed   = !core_reset   && (run_cnt == sq_delay);
  assign t_core_squeezed = !t_core_reset && (t_run_cnt == t_sq_delay);

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0]  rv;
    len_t          len;
    logic [N-1:0]  exp_grant;
    logic [IW-1:0] exp_id;
    logic          exp_err;
  } vec_t;

  vec_t vecs[11];

  function automatic rate_t msg_of(input int i);
    return {34{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic rate_t hash_of(input int i);
    return {34{32'h5A00_0000 + 32'(i)}};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_wide(input string name, input rate_t got, input rate_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got low bits %h expected %h", name, got[127:0], exp[127:0]);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic set_len(input len_t len);
    for (int i = 0; i < N; i++) req_length[i*LEN_W +: LEN_W] = len;
  endtask

  task automatic wait_rsp(input int budget);
    int waited = 0;
    while (!rsp_valid && waited < budget) begin
      tick();
      waited++;
    end
    check("rsp_valid_wait", rsp_valid, 1);
  endtask

  rate_t exp_hash;

  initial begin
    req_valid = '0; rsp_ready = 1'b1; core_hash = '0; req_length = '0;
    t_req_valid = '0; t_rsp_ready = 1'b1; t_core_hash = '0; t_req_length = '0;
    for (int i = 0; i < N; i++) begin
      req_message[i*RATE_BITS +: RATE_BITS]   = msg_of(i);
      t_req_message[i*RATE_BITS +: RATE_BITS] = msg_of(i);
    end

    vecs[0]  = '{4'b1111, 11'd0,    4'b0001, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 11'd1088, 4'b0010, 2'd1, 1'b0};
    vecs[2]  = '{4'b1111, 11'd100,  4'b0100, 2'd2, 1'b0};
    vecs[3]  = '{4'b1111, 11'd1089, 4'b1000, 2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 11'd8,    4'b0001, 2'd0, 1'b0};
    vecs[5]  = '{4'b1010, 11'd8,    4'b0010, 2'd1, 1'b0};
    vecs[6]  = '{4'b1010, 11'd2047, 4'b1000, 2'd3, 1'b1};
    vecs[7]  = '{4'b0001, 11'd16,   4'b0001, 2'd0, 1'b0};
    vecs[8]  = '{4'b0001, 11'd16,   4'b0001, 2'd0, 1'b0};
    vecs[9]  = '{4'b1100, 11'd1,    4'b0100, 2'd2, 1'b0};
    vecs[10] = '{4'b0011, 11'd5,    4'b0001, 2'd0, 1'b0};

    // Reset values while reset is held.
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_id", rsp_id, 0);
    check_wide("rst_rsp_hash", rsp_hash, '0);
    check("rst_busy", busy, 0);
    check_wide("rst_core_message", core_message, '0);
    check("rst_core_length", core_length, 0);
    check("rst_core_reset", core_reset, 1);
    reset = 1'b1;
    tick();

    // Table-driven jobs: arbitration order, latching, length check.
    sq_delay = 3;
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].rv;
      set_len(vecs[i].len);
      core_hash = hash_of(i);
      #1;
      check($sformatf("v%0d_grant", i), req_ready, vecs[i].exp_grant);
      tick();
      req_valid = '0;
      check_wide($sformatf("v%0d_core_message", i), core_message, msg_of(int'(vecs[i].exp_id)));
      check($sformatf("v%0d_core_length", i), core_length, vecs[i].len);
      wait_rsp(60);
      check($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].exp_id);
      check($sformatf("v%0d_rsp_error", i), rsp_error, vecs[i].exp_err);
      check_wide($sformatf("v%0d_rsp_hash", i), rsp_hash, vecs[i].exp_err ? '0 : hash_of(i));
      tick();
      check($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Single job with exact latency, then 50 cycles of backpressure.
    sq_delay  = 24;
    rsp_ready = 1'b0;
    core_hash = {34{32'h1234_56A5}};
    exp_hash  = core_hash;
    req_valid = 4'b0100;
    set_len(11'd0);
    #1;
    check("single_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("single_load1_core_reset", core_reset, 1);
    check("single_load1_busy", busy, 1);
    tick();
    check("single_load2_core_reset", core_reset, 1);
    tick();
    check("single_run_core_reset", core_reset, 0);
    repeat (24) tick();
    check("single_s_rsp_valid", rsp_valid, 0);
    tick();
    check("single_s1_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 2);
    check("single_rsp_error", rsp_error, 0);
    check("single_hash_lsb", rsp_hash[7:0], 8'hA5);
    check_wide("single_hash", rsp_hash, exp_hash);
    req_valid = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      core_hash = hash_of(100 + c);
      #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 2);
      check_wide("bp_rsp_hash", rsp_hash, exp_hash);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_rsp_valid", rsp_valid, 0);
    check("bp_release_busy", busy, 0);
    #1;
    check("bp_next_grant", req_ready, 4'b1000);
    req_valid = '0;

    // Bad length: straight to RESP, core stays in reset.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_len(11'd1089);
    #1;
    check("badlen_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("badlen_rsp_valid", rsp_valid, 1);
    check("badlen_rsp_error", rsp_error, 1);
    check_wide("badlen_rsp_hash", rsp_hash, '0);
    check("badlen_rsp_id", rsp_id, 1);
    check("badlen_core_reset0", core_reset, 1);
    tick();
    check("badlen_core_reset1", core_reset, 1);
    check("badlen_hold_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    check("badlen_done_valid", rsp_valid, 0);

    // Timeout: 16 RUN cycles, then error; squeeze on the 16th cycle wins.
    for (int v = 0; v < 2; v++) begin
      t_sq_delay  = (v == 0) ? 1000 : 15;
      t_core_hash = hash_of(200 + v);
      t_req_valid = 4'b0001;
      for (int i = 0; i < N; i++) t_req_length[i*LEN_W +: LEN_W] = 11'd8;
      #1;
      check($sformatf("to%0d_grant", v), t_req_ready, 4'b0001);
      tick();
      t_req_valid = '0;
      tick();
      tick();
      check($sformatf("to%0d_core_reset_fall", v), t_core_reset, 0);
      repeat (15) tick();
      check($sformatf("to%0d_run16_valid", v), t_rsp_valid, 0);
      check($sformatf("to%0d_run16_core_reset", v), t_core_reset, 0);
      tick();
      check($sformatf("to%0d_rsp_valid", v), t_rsp_valid, 1);
      check($sformatf("to%0d_rsp_error", v), t_rsp_error, (v == 0) ? 1 : 0);
      check_wide($sformatf("to%0d_rsp_hash", v), t_rsp_hash, (v == 0) ? '0 : hash_of(201));
      tick();
      check($sformatf("to%0d_idle", v), t_busy, 0);
    end

    // Reset asserted mid-RUN, between clock edges.
    sq_delay  = 1000;
    req_valid = 4'b0100;
    set_len(11'd0);
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("mid_run_core_reset", core_reset, 0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check_wide("mid_rst_core_message", core_message, '0);
    #1 reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("mid_rst_next_grant", req_ready, 4'b0001);
    sq_delay = 3;
    tick();
    req_valid = '0;
    wait_rsp(60);
    check("mid_rst_rsp_id", rsp_id, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
